// File: rtl/out_port_uart_tx.sv
// Output-port UART transmitter: decodes data/control writes from the core's
// output buses, queues bytes in a FIFO and sends them as 8N1 frames on tx.
module out_port_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   address_bus,
    input  logic [7:0]                    data_bus,
    input  logic                          wr_stb,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n;
    logic            tx_q, tx_n;
    logic            pop, wrap;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count_q;
    logic            push_req, push, drop, clr;

    assign push_req = wr_stb && (address_bus == BASE_ADDR);
    assign clr      = wr_stb && (address_bus == BASE_ADDR + 16'd1) && data_bus[0];
    // A pop on the same edge frees the slot, so a push while full still lands.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    assign full       = (count_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_count = count_q;
    assign busy       = (state != IDLE) || (count_q != '0);
    assign tx         = tx_q;
    assign wrap       = (cnt == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_n = state;
        cnt_n   = wrap ? '0 : cnt + BW'(1);
        bit_n   = bit_idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (wrap) begin
                    state_n = DATA;
                    bit_n   = '0;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = shift[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (wrap) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (drop)     overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_bus;
    end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Bench for out_port_uart_tx: frame-level reference model checked every cycle,
// plus vector table and hand sequences for overflow, same-edge and reset cases.
module tb_out_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int F     = 10 * CPB;
    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address_bus = '0;
    logic [7:0]  data_bus = '0;
    logic        wr_stb = 1'b0;
    logic        tx, busy, full, overflow;
    logic [3:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    out_port_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .address_bus(address_bus), .data_bus(data_bus),
        .wr_stb(wr_stb), .tx(tx), .busy(busy), .full(full),
        .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted bytes, byte on the wire, position in frame (-1 idle).
    logic [7:0] q [$];
    logic [7:0] cur;
    int         t = -1;
    bit         m_ov = 0;

    function automatic logic exp_tx();
        int idx;
        if (t < 0) return 1'b1;
        idx = t / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[idx-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        check("tx", tx, exp_tx());
        check("busy", busy, (t >= 0 || q.size() != 0));
        check("full", full, q.size() == DEPTH);
        check("overflow", overflow, m_ov);
        check("fifo_count", fifo_count, q.size());
    endtask

    task automatic model_edge(input bit s, input logic [15:0] a, input logic [7:0] d);
        int n;
        bit pop, pr, clr;
        n   = q.size();
        pop = (t < 0 || t == F-1) && n != 0;
        pr  = s && a == BASE;
        clr = s && a == BASE + 16'd1 && d[0];
        if (pop) begin
            cur = q.pop_front();
            t = 0;
        end else if (t >= 0) begin
            t = (t == F-1) ? -1 : t + 1;
        end
        if (pr && (n < DEPTH || pop)) q.push_back(d);
        if (pr && n == DEPTH && !pop) m_ov = 1;
        else if (clr)                 m_ov = 0;
    endtask

    task automatic step(input bit s, input logic [15:0] a, input logic [7:0] d);
        wr_stb = s; address_bus = a; data_bus = d;
        @(posedge clk);
        model_edge(s, a, d);
        #1;
        check_model();
        wr_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic model_reset();
        q.delete();
        t = -1;
        m_ov = 0;
    endtask

    typedef struct {
        bit          stb;
        logic [15:0] addr;
        logic [7:0]  data;
        int          exp_count;
        bit          exp_full;
        bit          exp_ov;
    } vec_t;

    vec_t tbl [15];
    logic [9:0] a5_frame;

    initial begin
        // Ten pushes into a depth-8 FIFO, then control-port writes.
        tbl[0]  = '{1'b1, 16'hFF00, 8'h10, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'hFF00, 8'h11, 1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'hFF00, 8'h12, 2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 16'hFF00, 8'h13, 3, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'hFF00, 8'h14, 4, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'hFF00, 8'h15, 5, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'hFF00, 8'h16, 6, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'hFF00, 8'h17, 7, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'hFF00, 8'h18, 8, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 16'hFF00, 8'h19, 8, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 16'hFF01, 8'h00, 8, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 16'hFF02, 8'h01, 8, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 16'hFF01, 8'h01, 8, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 16'hFF00, 8'h20, 8, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 16'hFF01, 8'h03, 8, 1'b1, 1'b0};

        // Reset held while idle.
        #23;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_count", fifo_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single frame of 8'hA5, bit by bit.
        a5_frame = {1'b1, 8'hA5, 1'b0};
        step(1'b1, BASE, 8'hA5);
        check("a5_pre_tx", tx, 1'b1);
        for (int k = 1; k <= F; k++) begin
            step(1'b0, 16'h0000, 8'h00);
            check("a5_bit", tx, a5_frame[(k-1)/CPB]);
            check("a5_busy", busy, 1'b1);
        end
        step(1'b0, 16'h0000, 8'h00);
        check("a5_done_busy", busy, 1'b0);
        check("a5_done_tx", tx, 1'b1);

        // Back-to-back frames with no gap.
        step(1'b1, BASE, 8'h01);
        check("b2b_cnt0", fifo_count, 1);
        step(1'b1, BASE, 8'h80);
        check("b2b_cnt1", fifo_count, 1);
        idle(F-1);
        check("b2b_stop_tx", tx, 1'b1);
        step(1'b0, 16'h0000, 8'h00);
        check("b2b_cnt2", fifo_count, 0);
        check("b2b_start2", tx, 1'b0);
        idle(F + 5);

        // Overflow and control-port vectors.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].stb, tbl[i].addr, tbl[i].data);
            check("vec_count", fifo_count, tbl[i].exp_count);
            check("vec_full", full, tbl[i].exp_full);
            check("vec_ov", overflow, tbl[i].exp_ov);
        end

        // Push into a full FIFO on the edge where STOP pops.
        for (int i = 0; i < 2*F && t != F-1; i++) step(1'b0, 16'h0000, 8'h00);
        check("pp_pre_full", full, 1'b1);
        step(1'b1, BASE, 8'h5A);
        check("pp_count", fifo_count, 8);
        check("pp_ov", overflow, 1'b0);
        idle(10*F + 10);
        check("drain_busy", busy, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            int r;
            logic [15:0] a;
            bit s;
            s = ((i / 600) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 7);
            a = (r < 5) ? BASE : (r == 5) ? BASE + 16'd1 : (r == 6) ? BASE + 16'd2 : 16'($urandom);
            step(s, a, 8'($urandom));
        end
        idle(10*F + 10);

        // Reset in the middle of DATA bit 3 with bytes queued.
        step(1'b1, BASE, 8'h3C);
        step(1'b1, BASE, 8'hC3);
        step(1'b1, BASE, 8'h77);
        idle(16);
        check("mid_pre_count", fifo_count, 2);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        idle(3*F);
        check("post_rst_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
